// File: rtl/bincounter_pkg.sv
// rtl/bincounter_pkg.sv - shared types for the 74161 counter model and its bench
package bincounter_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t TERM_COUNT = 4'hF;

endpackage

// File: rtl/bincounter_if.sv
// rtl/bincounter_if.sv - 74161 data/control/output pins bundled for board-level wiring
interface bincounter_if;
  import bincounter_pkg::*;

  logic pin3, pin4, pin5, pin6;
  logic pin7, pin8, pin9, pin10, pin16;
  logic pin11, pin12, pin13, pin14, pin15;

  // Q reassembled MSB..LSB as QD,QC,QB,QA
  function automatic nibble_t q();
    return {pin11, pin12, pin13, pin14};
  endfunction

  modport master (
    output pin3, pin4, pin5, pin6, pin7, pin8, pin9, pin10, pin16,
    input  pin11, pin12, pin13, pin14, pin15,
    import q
  );

  modport slave (
    input  pin3, pin4, pin5, pin6, pin7, pin8, pin9, pin10, pin16,
    output pin11, pin12, pin13, pin14, pin15
  );
endinterface

// File: rtl/bincounter.sv
// rtl/bincounter.sv - 74161 4-bit synchronous binary counter, async clear, sync load
module bincounter (
  input  logic pin1,
  input  logic pin2,
  input  logic pin3,
  input  logic pin4,
  input  logic pin5,
  input  logic pin6,
  input  logic pin7,
  input  logic pin8,
  input  logic pin9,
  input  logic pin10,
  output logic pin11,
  output logic pin12,
  output logic pin13,
  output logic pin14,
  output logic pin15,
  input  logic pin16
);
  localparam int unsigned WIDTH = 4;
  localparam logic [WIDTH-1:0] TERM = 4'hF;

  logic [WIDTH-1:0] count;
  logic             unused_pins;

  // Clear beats load, load beats count; load ignores ENP/ENT
  always_ff @(posedge pin2 or negedge pin1) begin
    if (!pin1) begin
      count <= '0;
    end else if (!pin9) begin
      count <= {pin6, pin5, pin4, pin3};
    end else if (pin7 && pin10) begin
      count <= count + 1'b1;
    end
  end

  assign {pin11, pin12, pin13, pin14} = count;
  assign pin15 = pin10 && (count == TERM);

  // Supply pins exist only for pin accuracy
  assign unused_pins = pin8 ^ pin16;
endmodule

// File: tb/tb_bincounter.sv
// tb/tb_bincounter.sv - scoreboard bench for the 74161 counter model
module tb_bincounter;
  import bincounter_pkg::*;

  logic pin1;
  logic pin2;
  bincounter_if bif ();

  bincounter dut (
    .pin1  (pin1),
    .pin2  (pin2),
    .pin3  (bif.pin3),
    .pin4  (bif.pin4),
    .pin5  (bif.pin5),
    .pin6  (bif.pin6),
    .pin7  (bif.pin7),
    .pin8  (bif.pin8),
    .pin9  (bif.pin9),
    .pin10 (bif.pin10),
    .pin11 (bif.pin11),
    .pin12 (bif.pin12),
    .pin13 (bif.pin13),
    .pin14 (bif.pin14),
    .pin15 (bif.pin15),
    .pin16 (bif.pin16)
  );

  int      checks = 0;
  int      errors = 0;
  nibble_t sbq[$];
  nibble_t model_q = '0;
  nibble_t exp_q;
  logic    exp_rco;

  initial pin2 = 1'b0;
  always #5 pin2 = ~pin2;

  task automatic drive(input logic clr_n, input logic load_n, input logic enp,
                       input logic ent, input nibble_t d);
    @(negedge pin2);
    pin1 = clr_n;
    bif.pin9 = load_n;
    bif.pin7 = enp;
    bif.pin10 = ent;
    {bif.pin6, bif.pin5, bif.pin4, bif.pin3} = d;
  endtask

  task automatic cycle();
    if (!pin1) model_q = '0;
    else if (!bif.pin9) model_q = {bif.pin6, bif.pin5, bif.pin4, bif.pin3};
    else if (bif.pin7 && bif.pin10) model_q = model_q + 4'd1;
    sbq.push_back(model_q);
    @(posedge pin2);
    #1;
  endtask

  task automatic test_reset();
    pin1 = 1'b1;
    bif.pin8 = 1'b0;
    bif.pin16 = 1'b1;
    bif.pin9 = 1'b1;
    bif.pin7 = 1'b0;
    bif.pin10 = 1'b1;
    {bif.pin6, bif.pin5, bif.pin4, bif.pin3} = 4'h0;
    #1 pin1 = 1'b0;
    #1;
    model_q = '0;
    checks++;
    if (bif.q() !== 4'h0) begin
      errors++;
      $display("FAIL reset_q got %b exp 0000", bif.q());
    end
    checks++;
    if (bif.pin15 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rco got %b exp 0", bif.pin15);
    end
  endtask

  task automatic test_clear_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
      cycle();
      exp_q = sbq.pop_front();
      checks++;
      if (bif.q() !== exp_q || bif.pin15 !== 1'b0) begin
        errors++;
        $display("FAIL clear_hold_%0d got q=%b rco=%b exp q=%b rco=0", i, bif.q(), bif.pin15, exp_q);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1010);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q || exp_q !== 4'b1010) begin
      errors++;
      $display("FAIL clear_release_load got %b exp %b", bif.q(), exp_q);
    end
  endtask

  task automatic test_load_ignores_enables();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1100);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q) begin
      errors++;
      $display("FAIL load_no_enable got %b exp %b", bif.q(), exp_q);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0011);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q) begin
      errors++;
      $display("FAIL load_beats_count got %b exp %b", bif.q(), exp_q);
    end
  endtask

  task automatic test_count_wrap();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b1101);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q) begin
      errors++;
      $display("FAIL wrap_load got %b exp %b", bif.q(), exp_q);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      exp_q = sbq.pop_front();
      exp_rco = (exp_q == TERM_COUNT);
      checks++;
      if (bif.q() !== exp_q || bif.pin15 !== exp_rco) begin
        errors++;
        $display("FAIL wrap_step_%0d got q=%b rco=%b exp q=%b rco=%b", i, bif.q(), bif.pin15, exp_q, exp_rco);
      end
    end
  endtask

  task automatic test_hold_rco();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111);
    cycle();
    void'(sbq.pop_front());
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q || bif.pin15 !== 1'b1) begin
      errors++;
      $display("FAIL hold_enp_low got q=%b rco=%b exp q=%b rco=1", bif.q(), bif.pin15, exp_q);
    end
    #2 bif.pin10 = 1'b0;
    #1;
    checks++;
    if (bif.pin15 !== 1'b0 || bif.q() !== exp_q) begin
      errors++;
      $display("FAIL rco_ent_gate got q=%b rco=%b exp q=%b rco=0", bif.q(), bif.pin15, exp_q);
    end
  endtask

  task automatic test_async_clear();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101);
    cycle();
    void'(sbq.pop_front());
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q) begin
      errors++;
      $display("FAIL async_pre got %b exp %b", bif.q(), exp_q);
    end
    #2 pin1 = 1'b0;
    #1;
    model_q = '0;
    checks++;
    if (bif.q() !== 4'h0) begin
      errors++;
      $display("FAIL async_clear got %b exp 0000", bif.q());
    end
    #1 pin1 = 1'b1;
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q || exp_q !== 4'b0001) begin
      errors++;
      $display("FAIL async_resume got %b exp %b", bif.q(), exp_q);
    end
  endtask

  task automatic test_clear_vs_load();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    cycle();
    exp_q = sbq.pop_front();
    checks++;
    if (bif.q() !== exp_q || bif.pin15 !== 1'b0) begin
      errors++;
      $display("FAIL clear_vs_load got q=%b rco=%b exp q=%b rco=0", bif.q(), bif.pin15, exp_q);
    end
  endtask

  initial begin
    test_reset();
    test_clear_hold();
    test_load_ignores_enables();
    test_count_wrap();
    test_hold_rco();
    test_async_clear();
    test_clear_vs_load();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
